// File: rtl/mips_pc_pkg.sv
// Shared definitions for the MIPS program-counter sequencer: PC width,
// reset address default and the sequencer state encoding.
package mips_pc_pkg;
  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } seq_state_e;
endpackage

// File: rtl/pc_target_calc.sv
// Redirect target formation: jump concatenation and word-offset branch target,
// both relative to the sequential address pc+4.
module pc_target_calc
  import mips_pc_pkg::*;
(
  input  logic [PC_W-1:0] pc_plus4,
  input  logic [25:0]     jump_index,
  input  logic [PC_W-1:0] branch_offset,
  output logic [PC_W-1:0] jump_target,
  output logic [PC_W-1:0] branch_target
);
  always_comb begin
    jump_target   = {pc_plus4[31:28], jump_index, 2'b00};
    // Top two offset bits fall off the shift; carry out of the add is dropped.
    branch_target = pc_plus4 + {branch_offset[PC_W-3:0], 2'b00};
  end
endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC register with a valid/ready fetch port and a one-entry
// buffer for a jump/branch redirect that arrives while fetch is stalled.
module pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  input  logic            stall,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  input  logic            jump_en,
  input  logic [25:0]     jump_index,
  input  logic            branch_en,
  input  logic [PC_W-1:0] branch_offset,
  output logic            redirect_pending,
  output logic [PC_W-1:0] fetch_count
);
  seq_state_e      state;
  logic [PC_W-1:0] pend_target;
  logic [PC_W-1:0] jump_target;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] pc_next;
  logic            done;

  always_comb begin
    pc_plus4 = pc + 32'd4;
  end

  pc_target_calc u_target_calc (
    .pc_plus4      (pc_plus4),
    .jump_index    (jump_index),
    .branch_offset (branch_offset),
    .jump_target   (jump_target),
    .branch_target (branch_target)
  );

  always_comb begin
    done = fetch_valid && fetch_ready && !stall;
  end

  // Live redirects outrank the buffered one; the buffer outranks sequential.
  always_comb begin
    pc_next = pc_plus4;
    if (jump_en)               pc_next = jump_target;
    else if (branch_en)        pc_next = branch_target;
    else if (redirect_pending) pc_next = pend_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= BOOT;
      fetch_valid      <= 1'b0;
      pc               <= RESET_PC;
      pend_target      <= '0;
      redirect_pending <= 1'b0;
      fetch_count      <= '0;
    end else begin
      case (state)
        BOOT: begin
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN, HOLD: begin
          state       <= done ? RUN : HOLD;
          fetch_valid <= 1'b1;
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
        end
      endcase

      if (done) begin
        pc               <= pc_next;
        fetch_count      <= fetch_count + 32'd1;
        redirect_pending <= 1'b0;
      end else if (jump_en) begin
        pend_target      <= jump_target;
        redirect_pending <= 1'b1;
      end else if (branch_en) begin
        pend_target      <= branch_target;
        redirect_pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected per-cycle outputs are queued as
// stimulus is driven and checked one cycle later against the DUT.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        jump_en;
  logic [25:0] jump_index;
  logic        branch_en;
  logic [31:0] branch_offset;
  logic        redirect_pending;
  logic [31:0] fetch_count;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        valid;
    logic        pend;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_valid      (fetch_valid),
    .fetch_ready      (fetch_ready),
    .stall            (stall),
    .pc               (pc),
    .pc_plus4         (pc_plus4),
    .jump_en          (jump_en),
    .jump_index       (jump_index),
    .branch_en        (branch_en),
    .branch_offset    (branch_offset),
    .redirect_pending (redirect_pending),
    .fetch_count      (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] epc, input logic ev,
                            input logic ep, input logic [31:0] ecnt);
    exp_t e;
    e.tag = tag; e.pc = epc; e.valid = ev; e.pend = ep; e.cnt = ecnt;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".pc"},       pc,                       e.pc);
      chk({e.tag, ".pc_plus4"}, pc_plus4,                 e.pc + 32'd4);
      chk({e.tag, ".valid"},    {31'd0, fetch_valid},      {31'd0, e.valid});
      chk({e.tag, ".pending"},  {31'd0, redirect_pending}, {31'd0, e.pend});
      chk({e.tag, ".count"},    fetch_count,              e.cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; fetch_ready = 1'b0; stall = 1'b0;
    jump_en = 1'b0; jump_index = '0; branch_en = 1'b0; branch_offset = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 32'h0, 1'b0, 1'b0, 32'd0); check_out();

    fetch_ready = 1'b1; rst_n = 1'b1;
    expect_out("startup", 32'h0, 1'b1, 1'b0, 32'd0); tick();
    expect_out("seq4",  32'h4, 1'b1, 1'b0, 32'd1); tick();
    expect_out("seq8",  32'h8, 1'b1, 1'b0, 32'd2); tick();
    expect_out("seq12", 32'hC, 1'b1, 1'b0, 32'd3); tick();

    branch_en = 1'b1; branch_offset = 32'h0000_003C;
    expect_out("br_to_100", 32'h0000_0100, 1'b1, 1'b0, 32'd4); tick();
    branch_offset = 32'hFFFF_FFFF;
    expect_out("br_minus1", 32'h0000_0100, 1'b1, 1'b0, 32'd5); tick();
    branch_offset = 32'hFFFF_FFBB;
    expect_out("br_to_fff0", 32'hFFFF_FFF0, 1'b1, 1'b0, 32'd6); tick();
    branch_en = 1'b0; jump_en = 1'b1; jump_index = 26'h200_0000;
    expect_out("jump_hi", 32'hF800_0000, 1'b1, 1'b0, 32'd7); tick();
    jump_en = 1'b0; branch_en = 1'b1; branch_offset = 32'h01FF_FFFE;
    expect_out("br_to_fffc", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'd8); tick();
    branch_en = 1'b0;
    expect_out("pc_wrap", 32'h0, 1'b1, 1'b0, 32'd9); tick();
    expect_out("after_wrap", 32'h4, 1'b1, 1'b0, 32'd10); tick();

    stall = 1'b1;
    expect_out("stall_hold1", 32'h4, 1'b1, 1'b0, 32'd10); tick();
    expect_out("stall_hold2", 32'h4, 1'b1, 1'b0, 32'd10); tick();
    stall = 1'b0;
    expect_out("stall_release", 32'h8, 1'b1, 1'b0, 32'd11); tick();

    fetch_ready = 1'b0; jump_en = 1'b1; jump_index = 26'h000_0010;
    expect_out("jump_buffered", 32'h8, 1'b1, 1'b1, 32'd11); tick();
    jump_en = 1'b0;
    expect_out("pending_hold", 32'h8, 1'b1, 1'b1, 32'd11); tick();
    fetch_ready = 1'b1;
    expect_out("pending_consumed", 32'h0000_0040, 1'b1, 1'b0, 32'd12); tick();

    fetch_ready = 1'b0; branch_en = 1'b1; branch_offset = 32'd4;
    expect_out("branch_buffered", 32'h40, 1'b1, 1'b1, 32'd12); tick();
    branch_en = 1'b0; jump_en = 1'b1; jump_index = 26'h000_0100;
    expect_out("jump_overwrites", 32'h40, 1'b1, 1'b1, 32'd12); tick();
    jump_en = 1'b0; fetch_ready = 1'b1;
    expect_out("newest_pending", 32'h0000_0400, 1'b1, 1'b0, 32'd13); tick();

    fetch_ready = 1'b0; jump_en = 1'b1; jump_index = 26'h000_0020;
    expect_out("pend_vs_live", 32'h400, 1'b1, 1'b1, 32'd13); tick();
    jump_en = 1'b0; fetch_ready = 1'b1; branch_en = 1'b1; branch_offset = 32'd1;
    expect_out("live_beats_pend", 32'h0000_0408, 1'b1, 1'b0, 32'd14); tick();
    jump_en = 1'b1; jump_index = 26'h000_0003; branch_offset = 32'd8;
    expect_out("jump_beats_branch", 32'h0000_000C, 1'b1, 1'b0, 32'd15); tick();
    jump_en = 1'b0; branch_en = 1'b0;

    fetch_ready = 1'b0;
    expect_out("pre_cnt_wrap", 32'hC, 1'b1, 1'b0, 32'd15); tick();
    force dut.fetch_count = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_count;
    fetch_ready = 1'b1;
    expect_out("cnt_wrap", 32'h10, 1'b1, 1'b0, 32'd0); tick();

    fetch_ready = 1'b0; jump_en = 1'b1; jump_index = 26'h000_0005;
    expect_out("pend_before_rst", 32'h10, 1'b1, 1'b1, 32'd0); tick();
    jump_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_reset", 32'h0, 1'b0, 1'b0, 32'd0); check_out();
    @(posedge clk);
    #1;
    fetch_ready = 1'b1; rst_n = 1'b1;
    expect_out("restart", 32'h0, 1'b1, 1'b0, 32'd0); tick();
    expect_out("pend_lost", 32'h4, 1'b1, 1'b0, 32'd1); tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter sequencer for the MIPS datapath. It is the consumer of the jump-target concatenation. It holds the architectural PC and forms PC+4, the jump target {PC+4[31:28], index, 2'b00} and the branch target. It issues fetch requests to instruction memory over a valid/ready handshake and buffers one redirect (jump or branch) that arrives while the fetch is stalled.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_valid  out  1  a fetch request at `pc` is presented.
- fetch_ready  in  1  instruction memory accepts the request. Handshake completes when fetch_valid && fetch_ready && !stall.
- stall  in  1  datapath hold. It blocks completion even when fetch_ready=1.
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc + 4, modulo 2^32 (combinational from `pc`).
- jump_en  in  1  single-cycle redirect request, jump form.
- jump_index  in  26  instruction index field.
- branch_en  in  1  single-cycle redirect request, branch form.
- branch_offset  in  32  sign-extended immediate, in words.
- redirect_pending  out  1  a buffered redirect is waiting.
- fetch_count  out  32  number of completed handshakes, wrapping.

## Operation
- State machine states are BOOT, RUN and HOLD.
  - BOOT: entered on reset. fetch_valid=0. Moves to RUN on the first clock edge after rst_n is deasserted.
  - RUN: fetch_valid=1. On handshake completion, stays in RUN. If fetch_ready=0 or stall=1, moves to HOLD.
  - HOLD: fetch_valid=1 and pc is held. Moves back to RUN on handshake completion.
- Next-PC selection applies on handshake completion only. Priority order:
  - live jump_en,
  - then live branch_en,
  - then the pending buffer,
  - then pc_plus4.
- Jump target is {pc_plus4[31:28], jump_index, 2'b00}.
- Branch target is pc_plus4 + (branch_offset << 2). The addition is 32-bit and discards the carry.
- Redirect buffering:
  - A jump_en or branch_en cycle without handshake completion captures the computed target into the pending register and sets redirect_pending.
  - A newer redirect overwrites the pending one. Jump wins over branch in the same cycle.
  - Completion consumes the pending target and clears redirect_pending, unless a live redirect is present. In that case the live target wins and pending is still cleared.
- fetch_count increments by 1 on each completion and wraps from 32'hFFFF_FFFF to 0.
- Sequential PC wraps from 32'hFFFF_FFFC to 32'h0000_0000.
- Low address bits are not checked. pc[1:0] keeps whatever a target supplies (jumps always give 2'b00).

## Timing
- Reset values:
  - pc = RESET_PC
  - pc_plus4 = RESET_PC + 4
  - fetch_valid = 0
  - redirect_pending = 0
  - fetch_count = 0
  - state = BOOT
- Reset is asynchronous. Asserting rst_n=0 mid-HOLD or with a redirect pending discards everything immediately.
- Startup: first fetch_valid=1 appears 1 cycle after the rst_n deassertion edge.
- Latency: the redirect target appears on `pc` in the cycle after the completing edge. This is one cycle, with zero bubbles when fetch_ready=1 and stall=0.
- pc, fetch_valid and pc_plus4 are stable while the block is in HOLD.
- jump_en/branch_en are sampled every cycle, including BOOT. A redirect in BOOT is buffered.

## Structure
- Shared package mips_pc_pkg holds:
  - the RESET_PC default constant,
  - the state enum (BOOT/RUN/HOLD),
  - the PC-width localparam.
- One sub-module, pc_target_calc: combinational. Takes pc_plus4, jump_index and branch_offset. Produces jump_target and branch_target.

## Test plan
- Reset with RESET_PC=0, hold fetch_ready=1, stall=0 → pc = 0, 4, 8 on successive cycles; fetch_count=3 after three completions.
- pc=32'hFFFF_FFF0, jump_en=1, jump_index=26'h200_0000 with a completing handshake → next pc=32'hF800_0000.
- pc=32'h0000_0100, branch_en=1, branch_offset=32'hFFFF_FFFF, completing → next pc=32'h0000_0100.
- fetch_ready=0, pulse jump_en with jump_index=26'h000_0010 → redirect_pending=1 and pc held. Raise fetch_ready → next pc={pc_plus4[31:28], 26'h10, 2'b00}, then redirect_pending=0.
- pc=32'hFFFF_FFFC with no redirect, completing → pc=32'h0000_0000. Preset fetch_count to 32'hFFFF_FFFF and complete → fetch_count=0.
- Drive a pending redirect, then pulse rst_n low mid-cycle → outputs go to reset values asynchronously and the pending redirect is lost.
